// File: rtl/riscv_pkg.sv
// Shared RV32 pipeline types and constants used by the memory stage and its
// data-memory handshake.
package riscv_pkg;

  localparam int XLEN             = 32;
  localparam int WORD_OFFSET_BITS = 2;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } mem_state_t;

  function automatic logic isWordAligned(input logic [XLEN-1:0] addr);
    return addr[WORD_OFFSET_BITS-1:0] == '0;
  endfunction

endpackage

// File: rtl/memory_stage_if.sv
// Data-memory request/response bus between the memory stage (master) and the
// data memory (slave).
interface memory_stage_if #(
  parameter int DMEM_ADDR_W = 32
);
  import riscv_pkg::*;

  logic                   dmem_req;
  logic                   dmem_we;
  logic [DMEM_ADDR_W-1:0] dmem_addr;
  logic [XLEN-1:0]        dmem_wdata;
  logic                   dmem_gnt;
  logic                   dmem_rvalid;
  logic [XLEN-1:0]        dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );

endinterface

// File: rtl/dmem_handshake_fsm.sv
// Request/response sequencer for data-memory accesses; freezes the pipeline
// while the access held in M is outstanding.
module dmem_handshake_fsm
  import riscv_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic mem_op_e_i,
  input  logic store_m_i,
  input  logic dmem_gnt_i,
  input  logic dmem_rvalid_i,
  output logic stall_m_o,
  output logic dmem_req_o
);

  mem_state_t state_q, state_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Leaving REQ/RESP without a stall is also a pipeline advance, so the next
  // aligned op in E can be issued straight away with no idle cycle.
  always_comb begin
    state_d    = state_q;
    stall_m_o  = 1'b0;
    dmem_req_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        state_d = mem_op_e_i ? REQ : IDLE;
      end
      REQ: begin
        dmem_req_o = 1'b1;
        if (dmem_gnt_i && store_m_i) begin
          state_d = mem_op_e_i ? REQ : IDLE;
        end else if (dmem_gnt_i) begin
          state_d   = RESP;
          stall_m_o = 1'b1;
        end else begin
          stall_m_o = 1'b1;
        end
      end
      RESP: begin
        if (dmem_rvalid_i) begin
          state_d = mem_op_e_i ? REQ : IDLE;
        end else begin
          stall_m_o = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// RV32 memory stage: E/M pipeline register, data-memory access and the M/W
// pipeline register feeding writeback and forwarding.
module memory_stage
  import riscv_pkg::*;
#(
  parameter int DMEM_ADDR_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] execute_out_e,
  input  logic [XLEN-1:0] reg_readdata2_m,
  input  logic [4:0]      reg_write_addr_m,
  input  logic            reg_write_en_m,
  input  logic            dmem_read_en_m,
  input  logic            dmem_write_en_m,
  input  logic            reg_writedata_sel_m,
  output logic [XLEN-1:0] execute_out_m,
  output logic            stall_m,
  output logic            misalign_fault_m,
  memory_stage_if.master  dmem,
  output logic [4:0]      reg_write_addr_w,
  output logic            reg_write_en_w,
  output logic [XLEN-1:0] reg_writedata_w,
  output logic [XLEN-1:0] execute_out_w
);

  logic [XLEN-1:0] execOut_q;
  logic [XLEN-1:0] storeData_q;
  logic [4:0]      regWriteAddr_q;
  logic            regWriteEn_q;
  logic            store_q;
  logic            wbSel_q;
  logic            misalign_q;

  logic [4:0]      regWriteAddrW_q;
  logic            regWriteEnW_q;
  logic [XLEN-1:0] regWriteDataW_q;
  logic [XLEN-1:0] execOutW_q;

  logic            memAccessE;
  logic            memOpE;
  logic            storeD;
  logic            misalignD;
  logic            dmemReq;

  assign memAccessE = dmem_read_en_m | dmem_write_en_m;
  assign memOpE     = memAccessE & isWordAligned(execute_out_e);
  assign misalignD  = memAccessE & ~isWordAligned(execute_out_e);
  // A simultaneous read and write is executed as a load only.
  assign storeD     = dmem_write_en_m & ~dmem_read_en_m;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      execOut_q      <= '0;
      storeData_q    <= '0;
      regWriteAddr_q <= '0;
      regWriteEn_q   <= 1'b0;
      store_q        <= 1'b0;
      wbSel_q        <= 1'b0;
      misalign_q     <= 1'b0;
    end else if (!stall_m) begin
      execOut_q      <= execute_out_e;
      storeData_q    <= reg_readdata2_m;
      regWriteAddr_q <= reg_write_addr_m;
      regWriteEn_q   <= reg_write_en_m;
      store_q        <= storeD;
      wbSel_q        <= reg_writedata_sel_m;
      misalign_q     <= misalignD;
    end
  end

  dmem_handshake_fsm u_fsm (
    .clk           (clk),
    .rst           (rst),
    .mem_op_e_i    (memOpE),
    .store_m_i     (store_q),
    .dmem_gnt_i    (dmem.dmem_gnt),
    .dmem_rvalid_i (dmem.dmem_rvalid),
    .stall_m_o     (stall_m),
    .dmem_req_o    (dmemReq)
  );

  assign dmem.dmem_req   = dmemReq;
  assign dmem.dmem_we    = store_q;
  assign dmem.dmem_addr  = {execOut_q[DMEM_ADDR_W-1:WORD_OFFSET_BITS], {WORD_OFFSET_BITS{1'b0}}};
  assign dmem.dmem_wdata = storeData_q;

  // A stalled M stage sends a bubble downstream but keeps the W data fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regWriteAddrW_q <= '0;
      regWriteEnW_q   <= 1'b0;
      regWriteDataW_q <= '0;
      execOutW_q      <= '0;
    end else if (stall_m) begin
      regWriteEnW_q   <= 1'b0;
    end else begin
      regWriteEnW_q   <= regWriteEn_q & ~misalign_q;
      regWriteAddrW_q <= regWriteAddr_q;
      execOutW_q      <= execOut_q;
      regWriteDataW_q <= wbSel_q ? dmem.dmem_rdata : execOut_q;
    end
  end

  assign execute_out_m    = execOut_q;
  assign misalign_fault_m = misalign_q;
  assign reg_write_addr_w = regWriteAddrW_q;
  assign reg_write_en_w   = regWriteEnW_q;
  assign reg_writedata_w  = regWriteDataW_q;
  assign execute_out_w    = execOutW_q;

endmodule

// File: tb/tb_memory_stage.sv
// Randomized bench for memory_stage: a scripted data memory plus a
// transaction-level model of how long each instruction should occupy M.
module tb_memory_stage;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic        we;
    logic        rdEn;
    logic        wrEn;
    logic        sel;
    int          gntDelay;
    int          rvDelay;
  } instr_t;

  logic        clk;
  logic        rst;
  logic [31:0] execute_out_e;
  logic [31:0] reg_readdata2_m;
  logic [4:0]  reg_write_addr_m;
  logic        reg_write_en_m;
  logic        dmem_read_en_m;
  logic        dmem_write_en_m;
  logic        reg_writedata_sel_m;
  logic [31:0] execute_out_m;
  logic        stall_m;
  logic        misalign_fault_m;
  logic [4:0]  reg_write_addr_w;
  logic        reg_write_en_w;
  logic [31:0] reg_writedata_w;
  logic [31:0] execute_out_w;

  memory_stage_if #(.DMEM_ADDR_W(32)) dmemBus ();

  memory_stage #(.DMEM_ADDR_W(32)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .execute_out_e       (execute_out_e),
    .reg_readdata2_m     (reg_readdata2_m),
    .reg_write_addr_m    (reg_write_addr_m),
    .reg_write_en_m      (reg_write_en_m),
    .dmem_read_en_m      (dmem_read_en_m),
    .dmem_write_en_m     (dmem_write_en_m),
    .reg_writedata_sel_m (reg_writedata_sel_m),
    .execute_out_m       (execute_out_m),
    .stall_m             (stall_m),
    .misalign_fault_m    (misalign_fault_m),
    .dmem                (dmemBus),
    .reg_write_addr_w    (reg_write_addr_w),
    .reg_write_en_w      (reg_write_en_w),
    .reg_writedata_w     (reg_writedata_w),
    .execute_out_w       (execute_out_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          assertCount;
  int          failCount;
  logic [31:0] memArr [64];
  logic [31:0] refMem [64];

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input instr_t t);
    execute_out_e       = t.addr;
    reg_readdata2_m     = t.wdata;
    reg_write_addr_m    = t.rd;
    reg_write_en_m      = t.we;
    dmem_read_en_m      = t.rdEn;
    dmem_write_en_m     = t.wrEn;
    reg_writedata_sel_m = t.sel;
  endtask

  function automatic instr_t genInstr();
    instr_t t;
    int     kind;
    kind   = int'($urandom_range(0, 9));
    t.rdEn = (kind >= 3 && kind <= 5) || kind == 9;
    t.wrEn = (kind >= 6);
    t.addr = $urandom;
    if ((t.rdEn || t.wrEn) && $urandom_range(0, 5) != 0) t.addr[1:0] = 2'b00;
    t.wdata    = $urandom;
    t.rd       = 5'($urandom);
    t.we       = 1'($urandom);
    t.sel      = t.rdEn ? ($urandom_range(0, 4) != 0) : 1'($urandom);
    t.gntDelay = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
    t.rvDelay  = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 2));
    return t;
  endfunction

  instr_t      zeroInstr;
  instr_t      m;
  instr_t      eNext;
  instr_t      t;
  int          cyc;
  int          total;
  bit          isMem, isLoad, isStore, reqPhase, gntNow, rvNow, expStall, accept, misal;
  logic [5:0]  loadIdx;
  logic [31:0] rdataDriven;
  logic        expWe;
  logic [4:0]  expWAddr;
  logic [31:0] expWExec;
  logic [31:0] expWData;

  initial begin
    assertCount = 0;
    failCount   = 0;
    zeroInstr   = '{default: '0};
    loadIdx     = '0;
    for (int i = 0; i < 64; i++) begin
      memArr[i] = $urandom;
      refMem[i] = memArr[i];
    end

    rst = 1'b1;
    applyStimulus(zeroInstr);
    dmemBus.dmem_gnt    = 1'b0;
    dmemBus.dmem_rvalid = 1'b0;
    dmemBus.dmem_rdata  = '0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_stall", stall_m, 0);
    checkOutput("rst_req", dmemBus.dmem_req, 0);
    checkOutput("rst_we", dmemBus.dmem_we, 0);
    checkOutput("rst_addr", dmemBus.dmem_addr, 0);
    checkOutput("rst_wdata", dmemBus.dmem_wdata, 0);
    checkOutput("rst_misalign", misalign_fault_m, 0);
    checkOutput("rst_exec_m", execute_out_m, 0);
    checkOutput("rst_we_w", reg_write_en_w, 0);
    checkOutput("rst_waddr_w", reg_write_addr_w, 0);
    checkOutput("rst_wdata_w", reg_writedata_w, 0);
    checkOutput("rst_exec_w", execute_out_w, 0);
    rst = 1'b0;

    m        = zeroInstr;
    cyc      = 0;
    expWe    = 1'b0;
    expWAddr = '0;
    expWExec = '0;
    expWData = '0;
    eNext    = genInstr();
    applyStimulus(eNext);

    // Each pass covers one clock cycle: memory responds, outputs are checked,
    // then the model decides whether the instruction in M retires at the edge.
    repeat (600) begin
      isMem    = (m.rdEn || m.wrEn) && (m.addr[1:0] == 2'b00);
      isLoad   = isMem && m.rdEn;
      isStore  = isMem && !m.rdEn;
      misal    = (m.rdEn || m.wrEn) && (m.addr[1:0] != 2'b00);
      total    = !isMem ? 1 : (isStore ? m.gntDelay + 1 : m.gntDelay + 2 + m.rvDelay);
      reqPhase = isMem && (cyc <= m.gntDelay);
      gntNow   = isMem && (cyc == m.gntDelay);
      rvNow    = isLoad && (cyc == total - 1);
      expStall = (cyc < total - 1);

      if (gntNow) begin
        if (isStore) memArr[dmemBus.dmem_addr[7:2]] = dmemBus.dmem_wdata;
        else         loadIdx = dmemBus.dmem_addr[7:2];
      end
      rdataDriven         = rvNow ? memArr[loadIdx] : $urandom;
      dmemBus.dmem_gnt    = gntNow || (!reqPhase && $urandom_range(0, 1) == 1);
      dmemBus.dmem_rvalid = rvNow || (!(isLoad && cyc > m.gntDelay) && $urandom_range(0, 1) == 1);
      dmemBus.dmem_rdata  = rdataDriven;
      #1;

      checkOutput("stall_m", stall_m, expStall);
      checkOutput("dmem_req", dmemBus.dmem_req, reqPhase);
      if (reqPhase) begin
        checkOutput("dmem_we", dmemBus.dmem_we, isStore);
        checkOutput("dmem_addr", dmemBus.dmem_addr, {m.addr[31:2], 2'b00});
        checkOutput("dmem_wdata", dmemBus.dmem_wdata, m.wdata);
      end
      checkOutput("misalign", misalign_fault_m, misal);
      checkOutput("execute_out_m", execute_out_m, m.addr);
      checkOutput("reg_write_en_w", reg_write_en_w, expWe);
      checkOutput("reg_write_addr_w", reg_write_addr_w, expWAddr);
      checkOutput("execute_out_w", execute_out_w, expWExec);
      checkOutput("reg_writedata_w", reg_writedata_w, expWData);

      if (!expStall) begin
        expWe    = m.we && !misal;
        expWAddr = m.rd;
        expWExec = m.addr;
        expWData = !m.sel ? m.addr : (isLoad ? refMem[m.addr[7:2]] : rdataDriven);
        if (isStore) refMem[m.addr[7:2]] = m.wdata;
        m      = eNext;
        cyc    = 0;
        eNext  = genInstr();
        accept = 1'b1;
      end else begin
        expWe  = 1'b0;
        cyc++;
        accept = 1'b0;
      end

      @(posedge clk);
      #1;
      if (accept) applyStimulus(eNext);
      @(negedge clk);
    end

    // Abandon a load sitting in RESP with an asynchronous reset.
    rst                 = 1'b1;
    dmemBus.dmem_gnt    = 1'b1;
    dmemBus.dmem_rvalid = 1'b0;
    t       = zeroInstr;
    t.addr  = 32'h0000_0200;
    t.rdEn  = 1'b1;
    t.we    = 1'b1;
    t.sel   = 1'b1;
    t.rd    = 5'd7;
    applyStimulus(t);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("load_req", dmemBus.dmem_req, 1);
    checkOutput("load_addr", dmemBus.dmem_addr, 32'h0000_0200);
    checkOutput("load_req_stall", stall_m, 1);
    @(posedge clk);
    #1;
    checkOutput("resp_req", dmemBus.dmem_req, 0);
    checkOutput("resp_stall", stall_m, 1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_stall", stall_m, 0);
    checkOutput("async_rst_req", dmemBus.dmem_req, 0);
    checkOutput("async_rst_we_w", reg_write_en_w, 0);
    checkOutput("async_rst_exec_m", execute_out_m, 0);
    applyStimulus(zeroInstr);
    dmemBus.dmem_gnt = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("post_rst_stall", stall_m, 0);
    checkOutput("post_rst_req", dmemBus.dmem_req, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
# memory_stage

Memory stage of the 5-stage RV32 pipeline: owns the execute→memory pipeline register, runs the data-memory request/response handshake for loads and stores, and owns the memory→writeback pipeline register. It consumes `execute_out_e` and the `*_m` control/data signals the execute stage passes through. It returns `execute_out_m` and `execute_out_w` to execute for forwarding. It raises `stall_m` to freeze the upstream pipeline while a data access is outstanding.

## Interface
Parameters:
- `DMEM_ADDR_W`, default 32: width of `dmem_addr`; the low `DMEM_ADDR_W` bits of the effective address are used.

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `execute_out_e`  in  32  ALU result / effective address from execute
- `reg_readdata2_m`  in  32  store data (already forwarded)
- `reg_write_addr_m`  in  5  destination register
- `reg_write_en_m`  in  1  destination write enable
- `dmem_read_en_m`  in  1  load
- `dmem_write_en_m`  in  1  store
- `reg_writedata_sel_m`  in  1  1 = writeback memory data, 0 = writeback `execute_out_m`
- `execute_out_m`  out  32  registered execute result, forwarding source
- `stall_m`  out  1  freeze IF/ID/EX and the E/M register
- `misalign_fault_m`  out  1  the instruction in M is a misaligned memory access
- `dmem_req`  out  1  request valid
- `dmem_we`  out  1  1 = store
- `dmem_addr`  out  DMEM_ADDR_W  word-aligned byte address
- `dmem_wdata`  out  32  store data
- `dmem_gnt`  in  1  request accepted this cycle
- `dmem_rvalid`  in  1  read data valid this cycle
- `dmem_rdata`  in  32  read data
- `reg_write_addr_w`  out  5  registered destination register
- `reg_write_en_w`  out  1  registered write enable
- `reg_writedata_w`  out  32  registered writeback data
- `execute_out_w`  out  32  registered execute result, forwarding source

## Operation
E/M register:
- Loads all E-side inputs on every rising edge where `stall_m`=0.
- Holds all contents while `stall_m`=1.
- Records `misalign_fault_m` = (read|write) & (`execute_out_e[1:0]`≠0).
- Read and write asserted together is illegal; the instruction is treated as a read and the write is ignored.

FSM states and transitions:
- IDLE: at a load edge, if the incoming instruction is an aligned mem op → REQ, otherwise stay IDLE.
- REQ: `dmem_req`=1.
  - `dmem_gnt`=1 on a store → IDLE, or → REQ again if the next captured instruction is an aligned mem op.
  - `dmem_gnt`=1 on a load → RESP.
  - `dmem_gnt`=0 → stay in REQ.
- RESP: `dmem_req`=0.
  - `dmem_rvalid`=1 → IDLE, or → REQ if the next captured instruction is an aligned mem op.
  - Otherwise stay in RESP.

Stall and memory-bus outputs:
- `stall_m` (combinational) = (REQ & ¬(`dmem_gnt` & store)) | (RESP & ¬`dmem_rvalid`).
- `dmem_addr` = {`execute_out_m`[DMEM_ADDR_W-1:2], 2'b00}.
- `dmem_we` = store & ¬read.
- `dmem_wdata` = held `reg_readdata2_m`.
- `dmem_addr`, `dmem_we` and `dmem_wdata` stay stable from the first REQ cycle until `dmem_gnt`.
- `dmem_gnt` outside REQ and `dmem_rvalid` outside RESP are ignored.

M/W register:
- When `stall_m`=0:
  - `reg_write_en_w` ← held `reg_write_en` & ¬`misalign_fault_m`.
  - `reg_write_addr_w` ← held `reg_write_addr`.
  - `execute_out_w` ← `execute_out_m`.
  - `reg_writedata_w` ← `reg_writedata_sel` ? `dmem_rdata` : `execute_out_m`.
- When `stall_m`=1:
  - `reg_write_en_w` ← 0 (bubble).
  - All other W fields hold their values.

Misaligned accesses issue no request and cause no stall; the fault flag is visible for exactly the cycles the instruction occupies M.

## Timing
- Reset: all outputs 0, FSM=IDLE. This includes `stall_m`, `dmem_req`, `misalign_fault_m`, `reg_write_en_w` and all data buses.
- Reset asserted mid-access drops `dmem_req` immediately and the transaction is abandoned. The data memory shares `rst`, so it must abandon its side too.
- Non-memory op: 1 cycle in M, no stall.
- Store with same-cycle grant: 1 cycle in M, no stall.
- Each cycle of grant delay adds 1 stall cycle.
- Load with same-cycle grant and `dmem_rvalid` in the next cycle: 2 cycles in M, 1 stall cycle. Data reaches `reg_writedata_w` at the edge ending the RESP cycle.
- Back-to-back memory ops issue with no idle cycle between them.
- Forwarding: `execute_out_m` is valid 1 edge after execute, and `execute_out_w` 2 edges after.

## Structure
- Shared package `riscv_pkg`:
  - `mem_state_t` enum {IDLE, REQ, RESP}.
  - `XLEN`=32.
  - `WORD_OFFSET_BITS`=2.
- Sub-module `dmem_handshake_fsm`: state register, next-state logic, `stall_m`, `dmem_req`.
- The pipeline registers stay in the top module.

## Test plan
- Add op with `execute_out_e`=0x10 → `execute_out_m`=0x10 after 1 edge, `execute_out_w`=0x10 after 2 edges, `stall_m` never high.
- Store to 0x100, data 0xDEADBEEF, `dmem_gnt` tied 1 → one cycle with `dmem_req`=`dmem_we`=1, addr 0x100, wdata 0xDEADBEEF, `stall_m`=0.
- Load from 0x200, `dmem_gnt` delayed 3 cycles, `dmem_rvalid` 2 cycles after grant with rdata 0x12345678:
  - `stall_m` high for exactly 5 cycles and `dmem_addr` stable throughout.
  - `reg_write_en_w` pulses once and `reg_writedata_w`=0x12345678.
- Load to 0x202 → `misalign_fault_m`=1 for 1 cycle, `dmem_req` stays 0, `reg_write_en_w`=0.
- Back-to-back load then store, both immediately granted → second `dmem_req` in the cycle after the load's `dmem_rvalid`, no gap; stray `dmem_rvalid` in IDLE is ignored.
- Assert `rst` in RESP → `dmem_req`, `stall_m` and `reg_write_en_w` go 0 asynchronously and the FSM returns to IDLE.
